// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - FIFO drain stage sending bytes as async serial frames
// Pops one byte, waits for the registered read data, then shifts out start/data/parity/stop bits.
module fifo_serial_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam logic [7:0] BAUD_MAX  = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t     state_q, state_d;
    logic [7:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       rd_en_q, rd_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_end;

    assign bit_end = (baud_q == BAUD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && !fifo_empty) state_d = POP;
            POP:     state_d = WAIT;
            WAIT:    state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end && bit_q == STOP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and datapath: every bit state shares the same baud counter.
    always_comb begin
        baud_d  = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        rd_en_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (state_d == POP) begin
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                shift_d = fifo_rd_data;
                par_d   = ^fifo_rd_data;
                tx_d    = 1'b0;
            end
            START, DATA, PARITY, STOP: begin
                baud_d = bit_end ? 8'd0 : baud_q + 8'd1;
                if (bit_end) begin
                    case (state_q)
                        START: begin
                            tx_d    = shift_q[0];
                            shift_d = shift_q >> 1;
                            bit_d   = 3'd0;
                        end
                        DATA: begin
                            if (bit_q == 3'd7) begin
                                tx_d  = (PARITY_EN != 0) ? par_q : 1'b1;
                                bit_d = 3'd0;
                            end else begin
                                tx_d    = shift_q[0];
                                shift_d = shift_q >> 1;
                                bit_d   = bit_q + 3'd1;
                            end
                        end
                        PARITY: begin
                            tx_d  = 1'b1;
                            bit_d = 3'd0;
                        end
                        default: begin
                            if (bit_q == STOP_LAST) begin
                                busy_d = 1'b0;
                                done_d = 1'b1;
                            end else begin
                                bit_d = bit_q + 3'd1;
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - directed self-checking bench for fifo_serial_tx
module tb_fifo_serial_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_en, tx, busy, frame_done;

    logic       en2 = 1'b0;
    logic       empty2 = 1'b1;
    logic [7:0] rd_data2 = 8'h07;
    logic       rd_en2, tx2, busy2, done2;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops = 0;
    int empty_pops = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    // FIFO model with registered read data
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (rd_ptr == wr_ptr) empty_pops <= empty_pops + 1;
            else begin
                fifo_rd_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
            pops <= pops + 1;
        end
    end

    fifo_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .tx(tx),
        .busy(busy), .frame_done(frame_done)
    );

    fifo_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .enable(en2), .fifo_empty(empty2),
        .fifo_rd_data(rd_data2), .fifo_rd_en(rd_en2), .tx(tx2),
        .busy(busy2), .frame_done(done2)
    );

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Follows one 10-bit frame; drop_k/abort_k are cycle offsets from the start-bit edge (-1 = unused)
    task automatic run_frame(input logic [7:0] b, input int drop_k, input int abort_k, output int wait_cnt);
        logic exp_tx;
        int j;
        wait_cnt = 0;
        while (fifo_rd_en !== 1'b1 && wait_cnt < 300) begin
            @(negedge clk);
            wait_cnt++;
        end
        compared++;
        if (fifo_rd_en !== 1'b1) begin
            mismatched++;
            $display("FAIL pop_timeout: fifo_rd_en=%b required 1", fifo_rd_en);
            return;
        end
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL busy_at_pop: got %b required 1", busy); end
        @(negedge clk);
        compared++;
        if (fifo_rd_en !== 1'b0) begin mismatched++; $display("FAIL pop_width: fifo_rd_en=%b required 0", fifo_rd_en); end
        @(negedge clk);
        for (int k = 0; k < 10 * C; k++) begin
            if (k == drop_k) enable = 1'b0;
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                compared++;
                if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
                    mismatched++;
                    $display("FAIL async_reset: tx=%b busy=%b rd_en=%b required 1 0 0", tx, busy, fifo_rd_en);
                end
                return;
            end
            j = k / C;
            exp_tx = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
            compared++;
            if (tx !== exp_tx || frame_done !== 1'b0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL frame_bit byte=%h cycle=%0d: tx=%b done=%b busy=%b required tx=%b done=0 busy=1",
                         b, k, tx, frame_done, busy, exp_tx);
            end
            @(negedge clk);
        end
        compared++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            mismatched++;
            $display("FAIL frame_end byte=%h: done=%b busy=%b tx=%b required 1 0 1", b, frame_done, busy, tx);
        end
        @(negedge clk);
    endtask

    task automatic idle_no_pop(input int n, input string name);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
            @(negedge clk);
        end
        compared++;
        if (bad != 0) begin mismatched++; $display("FAIL %s: %0d active cycles required 0", name, bad); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: tx=%b rd_en=%b busy=%b done=%b required 1 0 0 0", tx, fifo_rd_en, busy, frame_done);
        end
        rst_n = 1'b1;
        enable = 1'b1;
        idle_no_pop(100, "empty_idle");
        compared++;
        if (pops !== 0) begin mismatched++; $display("FAIL empty_pops: got %0d required 0", pops); end
    endtask

    task automatic test_single_a5();
        int w;
        push(8'hA5);
        run_frame(8'hA5, -1, -1, w);
        idle_no_pop(20, "after_a5");
        compared++;
        if (pops !== 1) begin mismatched++; $display("FAIL a5_pops: got %0d required 1", pops); end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [7:0] seq [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
        foreach (seq[i]) push(seq[i]);
        for (int i = 0; i < 4; i++) begin
            run_frame(seq[i], -1, -1, w);
            if (i > 0) begin
                compared++;
                if (w !== 0) begin mismatched++; $display("FAIL gap_frame%0d: pop %0d cycles late required 0", i, w); end
            end
        end
        idle_no_pop(60, "after_b2b");
        compared++;
        if (pops !== 5 || empty_pops !== 0) begin
            mismatched++;
            $display("FAIL b2b_pops: pops=%0d empty_pops=%0d required 5 0", pops, empty_pops);
        end
    endtask

    task automatic test_parity_two_stop();
        int n = 0;
        logic [11:0] bits = 12'b1111_0000_0111 << 1;
        logic exp_tx;
        bits[0] = 1'b0;
        bits[9] = 1'b1;
        @(negedge clk);
        empty2 = 1'b0;
        en2 = 1'b1;
        while (rd_en2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        compared++;
        if (rd_en2 !== 1'b1) begin mismatched++; $display("FAIL par_pop: rd_en2=%b required 1", rd_en2); return; end
        empty2 = 1'b1;
        en2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 12 * C; k++) begin
            exp_tx = bits[k / C];
            compared++;
            if (tx2 !== exp_tx || done2 !== 1'b0) begin
                mismatched++;
                $display("FAIL par_bit cycle=%0d: tx=%b done=%b required tx=%b done=0", k, tx2, done2, exp_tx);
            end
            @(negedge clk);
        end
        compared++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || tx2 !== 1'b1) begin
            mismatched++;
            $display("FAIL par_end: done=%b busy=%b tx=%b required 1 0 1", done2, busy2, tx2);
        end
    endtask

    task automatic test_enable_drop();
        int w;
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        enable = 1'b1;
        run_frame(8'h3C, 4 * C + 1, -1, w);
        idle_no_pop(60, "after_drop");
        compared++;
        if (pops !== 6) begin mismatched++; $display("FAIL drop_pops: got %0d required 6", pops); end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int bad = 0;
        enable = 1'b1;
        run_frame(8'h11, -1, 6 * C + 1, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || tx !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
        end
        compared++;
        if (bad != 0) begin mismatched++; $display("FAIL reset_hold: %0d bad cycles required 0", bad); end
        rst_n = 1'b1;
        run_frame(8'h22, -1, -1, w);
        compared++;
        if (w !== 1) begin mismatched++; $display("FAIL restart_latency: %0d cycles required 1", w); end
        idle_no_pop(20, "after_restart");
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_parity_two_stop();
        test_enable_drop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
